// File: rtl/sumres_seq8_if.sv
// Handshake bundle for sumres_seq8: two valid/ready request ports and one
// valid/ready result port. The master drives requests; the slave is the sequencer.
interface sumres_seq8_if #(
  parameter int NIB = 2
);
  localparam int W = 4 * NIB;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_op;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_op;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_carry;
  logic         res_sign;
  logic         res_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_carry, res_sign, res_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_carry, res_sign, res_id
  );
endinterface

// File: rtl/sumres_seq8.sv
// Nibble-serial sign-magnitude add/subtract sequencer shared by two
// round-robin requesters; one 4-bit add/sub stage runs NIB cycles per operation.
module sumres_seq8 #(
  parameter int NIB = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  sumres_seq8_if.slave bus
);
  localparam int W  = 4 * NIB;
  localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [KW-1:0]       k;
  logic [NIB-1:0][3:0] a_q;
  logic [NIB-1:0][3:0] b_q;
  logic [NIB-1:0][3:0] data_q;
  logic                op_q;
  logic                carry_q;
  logic                ptr;
  logic                res_valid_q;
  logic                res_carry_q;
  logic                res_sign_q;
  logic                res_id_q;

  logic                gnt0;
  logic                gnt1;
  logic [W-1:0]        sel_a;
  logic [W-1:0]        sel_b;
  logic                sel_op;
  logic                swap;
  logic [4:0]          nib_sum;

  // Ready is the grant itself: combinational from valids and the pointer, and
  // forced low outside IDLE and while reset is held.
  always_comb begin
    // NOTE: every always_comb output is given a default first so no path infers a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && state == IDLE) begin
      gnt0 = bus.req0_valid && (!bus.req1_valid || !ptr);
      gnt1 = bus.req1_valid && (!bus.req0_valid ||  ptr);
    end
  end

  assign sel_a  = gnt1 ? bus.req1_a  : bus.req0_a;
  assign sel_b  = gnt1 ? bus.req1_b  : bus.req0_b;
  assign sel_op = gnt1 ? bus.req1_op : bus.req0_op;
  assign swap   = sel_op && (sel_a < sel_b);

  // Subtract is A + ~B + 1, with the +1 coming from the carry register seeded with op.
  assign nib_sum = {1'b0, a_q[k]} + {1'b0, b_q[k] ^ {4{op_q}}} + {4'b0000, carry_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      op_q        <= 1'b0;
      carry_q     <= 1'b0;
      ptr         <= 1'b0;
      res_valid_q <= 1'b0;
      res_carry_q <= 1'b0;
      res_sign_q  <= 1'b0;
      res_id_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            a_q        <= swap ? sel_b : sel_a;
            b_q        <= swap ? sel_a : sel_b;
            op_q       <= sel_op;
            carry_q    <= sel_op;
            res_sign_q <= swap;
            res_id_q   <= gnt1;
            ptr        <= !gnt1;
            k          <= '0;
            state      <= CALC;
          end
        end
        CALC: begin
          data_q[k] <= nib_sum[3:0];
          carry_q   <= nib_sum[4];
          if (k == KW'(NIB - 1)) begin
            res_carry_q <= nib_sum[4];
            res_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = data_q;
  assign bus.res_carry  = res_carry_q;
  assign bus.res_sign   = res_sign_q;
  assign bus.res_id     = res_id_q;
endmodule
